// File: rtl/uart_tx_drain_pkg.sv
// Shared definitions for the UART transmit-drain block: frame data width and FSM state encoding.
package uart_tx_drain_pkg;

  localparam int DATA_W    = 8;
  localparam int BIT_IDX_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_drain_baud_tick.sv
// Bit-time counter: counts 0..CLK_DIV-1 while run is high and flags the last cycle of each bit.
module baud_tick #(
  parameter int CLK_DIV = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  logic [15:0] count;

  assign tick = run && (count == 16'(CLK_DIV - 1));

  // Held at zero while idle so every frame starts on a fresh bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!run || tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that pulls bytes from an upstream FIFO and sends 8N1/8N2 frames back to back.
module uart_tx_drain
  import uart_tx_drain_pkg::*;
#(
  parameter int CLK_DIV   = 868,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic              empty,
  output logic              r,
  output logic              tx,
  output logic              busy
);

  state_t                 state;
  logic [DATA_W-1:0]      shift;
  logic [BIT_IDX_W-1:0]   bit_idx;
  logic                   stop_idx;
  logic                   tick;
  logic                   last_stop;
  logic                   pop;

  baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .run (busy),
    .tick(tick)
  );

  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

  // A pop is allowed when idle, or in the very last cycle of the final stop bit so frames abut.
  assign pop = !rst && en && !empty &&
               ((state == IDLE) || (state == STOP && tick && last_stop));
  assign r   = pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state <= START;
            shift <= din;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end
        DATA: begin
          // tx takes shift[1] because it becomes shift[0] after this shift.
          if (tick) begin
            shift   <= shift >> 1;
            tx      <= shift[1];
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BIT_IDX_W'(DATA_W - 1)) begin
              state    <= STOP;
              stop_idx <= 1'b0;
              tx       <= 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (!last_stop) begin
              stop_idx <= stop_idx + 1'b1;
            end else if (pop) begin
              state    <= START;
              shift    <= din;
              tx       <= 1'b0;
              stop_idx <= 1'b0;
            end else begin
              state    <= IDLE;
              tx       <= 1'b1;
              busy     <= 1'b0;
              stop_idx <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: two instances (CLK_DIV=4/8N1 and CLK_DIV=3/8N2) checked every cycle against a frame-timeline model.
module tb_uart_tx_drain;

  logic       clk;
  logic       rst;
  logic       en_a, en_b;
  logic [7:0] din_a, din_b;
  logic       empty_a, empty_b;
  logic       r_a, r_b, tx_a, tx_b, busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  int         m_left[2];
  int         m_pos[2];
  logic [7:0] m_byte[2];

  int busy_cnt_a, busy_cnt_b, r_cnt_a, r_cnt_b, txlow_cnt_b;

  uart_tx_drain #(.CLK_DIV(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .din(din_a), .empty(empty_a),
    .r(r_a), .tx(tx_a), .busy(busy_a)
  );

  uart_tx_drain #(.CLK_DIV(3), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .din(din_b), .empty(empty_b),
    .r(r_b), .tx(tx_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int div_of(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int frame_len(int d);
    return (d == 0) ? (9 + 1) * 4 : (9 + 2) * 3;
  endfunction

  // Expected line level from the position inside the current frame.
  function automatic logic exp_tx(int d);
    int idx;
    if (m_left[d] == 0) return 1'b1;
    idx = m_pos[d] / div_of(d);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[d][idx-1];
    return 1'b1;
  endfunction

  function automatic logic exp_r(int d);
    logic e, emp;
    e   = (d == 0) ? en_a : en_b;
    emp = (d == 0) ? (qa.size() == 0) : (qb.size() == 0);
    return !rst && e && !emp && (m_left[d] <= 1);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    empty_a = (qa.size() == 0);
    din_a   = empty_a ? 8'($urandom) : qa[0];
    empty_b = (qb.size() == 0);
    din_b   = empty_b ? 8'($urandom) : qb[0];
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_left[d] = 0;
      m_pos[d]  = 0;
    end
  endtask

  task automatic clear_stats();
    busy_cnt_a = 0; busy_cnt_b = 0; r_cnt_a = 0; r_cnt_b = 0; txlow_cnt_b = 0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic pop[2];
    @(negedge clk);
    check("r_a",    r_a,    exp_r(0));
    check("tx_a",   tx_a,   exp_tx(0));
    check("busy_a", busy_a, m_left[0] != 0);
    check("r_b",    r_b,    exp_r(1));
    check("tx_b",   tx_b,   exp_tx(1));
    check("busy_b", busy_b, m_left[1] != 0);
    if (busy_a) busy_cnt_a++;
    if (busy_b) busy_cnt_b++;
    if (r_a) r_cnt_a++;
    if (r_b) r_cnt_b++;
    if (!tx_b) txlow_cnt_b++;
    pop[0] = exp_r(0);
    pop[1] = exp_r(1);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_left[d] = 0;
      end else if (pop[d]) begin
        m_byte[d] = (d == 0) ? qa.pop_front() : qb.pop_front();
        m_left[d] = frame_len(d);
        m_pos[d]  = 0;
      end else if (m_left[d] > 0) begin
        m_left[d]--;
        m_pos[d]++;
      end
    end
    #1;
    drive_inputs();
  endtask

  task automatic run_cycles(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst  = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    model_reset();
    drive_inputs();
    #1;
    check("reset_tx_a",   tx_a,   1'b1);
    check("reset_busy_a", busy_a, 1'b0);
    check("reset_r_a",    r_a,    1'b0);
    check("reset_tx_b",   tx_b,   1'b1);
    check("reset_busy_b", busy_b, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Idle with the FIFO empty: no pops, line high.
    en_a = 1'b1;
    en_b = 1'b1;
    clear_stats();
    run_cycles(100);
    check("empty_r_cnt_a", r_cnt_a, 0);
    check("empty_r_cnt_b", r_cnt_b, 0);

    // Single 0x55 frame on the CLK_DIV=4 instance.
    clear_stats();
    qa.push_back(8'h55);
    drive_inputs();
    run_cycles(45);
    check("f55_busy_cycles", busy_cnt_a, 40);
    check("f55_pops",        r_cnt_a,    1);

    // Two frames back to back with no idle gap.
    clear_stats();
    qa.push_back(8'hA5);
    qa.push_back(8'h3C);
    drive_inputs();
    run_cycles(85);
    check("b2b_busy_cycles", busy_cnt_a, 80);
    check("b2b_pops",        r_cnt_a,    2);

    // 8N2 all-zero frame on the CLK_DIV=3 instance.
    clear_stats();
    qb.push_back(8'h00);
    drive_inputs();
    run_cycles(36);
    check("z_tx_low_cycles", txlow_cnt_b, 27);
    check("z_busy_cycles",   busy_cnt_b,  33);

    // Enable gating: nothing moves while en is low; a frame in flight completes.
    clear_stats();
    en_a = 1'b0;
    qa.push_back(8'h12);
    qa.push_back(8'h34);
    drive_inputs();
    run_cycles(20);
    check("en_low_pops", r_cnt_a, 0);
    en_a = 1'b1;
    run_cycles(10);
    en_a = 1'b0;
    run_cycles(50);
    check("en_drop_pops",   r_cnt_a,    1);
    check("en_drop_frame",  busy_cnt_a, 40);
    qa.delete();
    en_a = 1'b1;
    drive_inputs();

    // Random traffic with occasional enable toggles.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0 && qa.size() < 3) qa.push_back(8'($urandom));
      if ($urandom_range(0, 9) == 0 && qb.size() < 3) qb.push_back(8'($urandom));
      if ($urandom_range(0, 49) == 0) en_a = ~en_a;
      if ($urandom_range(0, 49) == 0) en_b = ~en_b;
      drive_inputs();
      step();
    end
    en_a = 1'b1;
    en_b = 1'b1;
    run_cycles(200);

    // Reset in the middle of the data bits of a 0xFF frame.
    qa.push_back(8'hFF);
    drive_inputs();
    run_cycles(15);
    #2 rst = 1'b1;
    #1;
    check("arst_tx_a",   tx_a,   1'b1);
    check("arst_busy_a", busy_a, 1'b0);
    check("arst_r_a",    r_a,    1'b0);
    model_reset();
    run_cycles(3);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    drive_inputs();
    clear_stats();
    run_cycles(20);
    check("post_rst_pops", r_cnt_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
